instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end that feeds the ControlUnit: fetches 16-bit instruction words from program memory over a req/ack handshake and latches them into an instruction register.
- Presents opcode[3:0] and operand[11:0] to the ControlUnit, then holds them stable until the ControlUnit reports completion.
- Maintains the program counter, applies taken branches, and halts on the HALT opcode or on a fetch timeout.

Parameters:
- ADDR_W, 8, program counter / memory address width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OP, 4'hF, opcode that stops fetching.
- TIMEOUT, 15, maximum FETCH cycles without mem_ack before fetch_err (must be ≥1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  read request to program memory.
- mem_addr  out  ADDR_W  read address; equals pc.
- mem_ack  in  1  memory read-data-valid strobe.
- mem_rdata  in  16  instruction word: [15:12] opcode, [11:0] operand.
- opcode  out  4  instruction-register opcode to the ControlUnit.
- operand  out  12  instruction-register operand field.
- instr_valid  out  1  opcode/operand hold a live instruction.
- instr_done  in  1  ControlUnit has finished the current instruction.
- branch_take  in  1  with instr_done: load branch_target into PC.
- branch_target  in  ADDR_W  branch destination.
- halted  out  1  unit is in HALT.
- fetch_err  out  1  sticky; set when a fetch times out.

Behaviour:
- Reset (synchronous, active-high; wins over all other inputs, including mid-fetch and mid-exec):
  - pc = RESET_PC; state = FETCH; mem_req = 0; opcode = 4'h0; operand = 0.
  - instr_valid = 0; halted = 0; fetch_err = 0; timeout counter = 0.
- mem_addr is combinational from pc.
- States: FETCH, EXEC, HALT.
- FETCH:
  - mem_req = 1; timeout counter increments each cycle.
  - On a cycle with mem_ack = 1, the next edge does all of the following:
    - IR <= mem_rdata; pc <= pc + 1 (mod 2^ADDR_W, so pc = 2^ADDR_W−1 wraps to 0).
    - mem_req <= 0; instr_valid <= 1; counter <= 0; state -> EXEC.
  - Minimum latency: ack in the first FETCH cycle gives instr_valid high 1 cycle after FETCH entry.
  - If the counter reaches TIMEOUT with no ack: fetch_err <= 1, mem_req <= 0, state -> HALT.
  - An ack arriving on the same cycle the counter reaches TIMEOUT counts as a success; the ack wins.
- EXEC:
  - mem_req = 0; opcode/operand held stable; instr_valid = 1.
  - mem_ack is ignored. branch_take is ignored unless instr_done = 1.
  - On instr_done = 1:
    - instr_valid <= 0.
    - If branch_take = 1, pc <= branch_target; this overrides the increment already applied.
    - If opcode == HALT_OP, state -> HALT and branch_take is ignored.
    - Otherwise state -> FETCH.
- HALT:
  - halted = 1; mem_req = 0; instr_valid = 0.
  - opcode/operand keep their last values.
  - All inputs are ignored; only reset exits HALT.
- mem_ack outside FETCH never changes the IR or the PC.
- instr_valid is never high in FETCH. opcode changes only on the accepting edge of a fetch.

Test Plan:
- Reset + straight-line fetch: reset 2 cycles, memory returns 16'h8123 at addr 0 with ack in the first FETCH cycle.
  -> mem_addr = 0, opcode = 8, operand = 12'h123, instr_valid high 1 cycle after FETCH entry, pc = 1.
  -> instr_done pulse -> next mem_addr = 1.
- Delayed ack: ack 3 cycles after mem_req rises.
  -> mem_req held high 3 cycles, IR loaded only on the ack edge, fetch_err = 0.
- Branch: at pc = 5 fetch 16'h2000, assert instr_done with branch_take = 1 and branch_target = 8'h40.
  -> next mem_addr = 8'h40.
  -> Same instruction with branch_take = 1 but no instr_done -> ignored, IR and pc unchanged.
- HALT and wrap: start at pc = 8'hFF, memory word 16'hF000.
  -> pc wraps to 0; after instr_done, halted = 1, mem_req stays 0 for 20 cycles despite acks.
  -> reset restores pc = 0 and halted = 0.
- Timeout: never ack.
  -> after TIMEOUT = 15 FETCH cycles, fetch_err = 1, halted = 1, mem_req = 0.
  -> Repeat with ack on exactly cycle 15 -> instruction accepted, fetch_err = 0.
- Reset mid-operation: assert reset during EXEC with instr_valid = 1.
  -> next cycle instr_valid = 0, opcode = 0, pc = RESET_PC, state FETCH after release.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Front end for the ControlUnit. Fetches 16-bit instruction words from
// program memory over a req/ack handshake, latches them into an instruction
// register, and holds opcode/operand stable until the ControlUnit reports
// completion. Owns the program counter, applies taken branches, and halts
// on the HALT opcode or when a fetch goes unanswered for TIMEOUT cycles.
//
// Ports:
//   clk            system clock, rising-edge
//   reset          synchronous, active-high reset
//   mem_req        read request to program memory (high throughout FETCH)
//   mem_addr       read address, always equal to the program counter
//   mem_ack        read-data-valid strobe from memory
//   mem_rdata      instruction word: [15:12] opcode, [11:0] operand
//   opcode         instruction-register opcode
//   operand        instruction-register operand
//   instr_valid    opcode/operand hold a live instruction (EXEC)
//   instr_done     ControlUnit finished the current instruction
//   branch_take    with instr_done: load branch_target into the PC
//   branch_target  branch destination
//   halted         unit is in HALT
//   fetch_err      sticky fetch-timeout flag
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                 ADDR_W   = 8,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter logic [3:0]         HALT_OP  = 4'hF,
   parameter int                 TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata,
   output logic [3:0]        opcode,
   output logic [11:0]       operand,
   output logic              instr_valid,
   input  logic              instr_done,
   input  logic              branch_take,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              halted,
   output logic              fetch_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // Counter value seen on the last permitted FETCH cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_HALT  = 2'd2;

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [CNT_W-1:0]  cnt;
   logic [3:0]        op_q;
   logic [11:0]       opd_q;
   logic              err_q;

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples pre-edge values; blocking here would let pc/state
   // updates race each other within the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         cnt   <= '0;
         op_q  <= 4'h0;
         opd_q <= 12'h000;
         err_q <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               // An ack on the final permitted cycle still wins over timeout.
               if (mem_ack) begin
                  op_q  <= mem_rdata[15:12];
                  opd_q <= mem_rdata[11:0];
                  pc    <= pc + 1'b1;
                  cnt   <= '0;
                  state <= S_EXEC;
               end else if (cnt == CNT_LAST) begin
                  err_q <= 1'b1;
                  cnt   <= '0;
                  state <= S_HALT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_EXEC: begin
               if (instr_done) begin
                  if (op_q == HALT_OP) begin
                     state <= S_HALT;
                  end else begin
                     // Overrides the increment applied when this word was fetched.
                     if (branch_take) pc <= branch_target;
                     state <= S_FETCH;
                  end
               end
            end
            S_HALT: begin
               // Only reset leaves HALT.
            end
            default: state <= S_HALT;
         endcase
      end
   end

   // The request is gated by reset so it reads low while reset is held,
   // and rises in the very first FETCH cycle after release.
   assign mem_req     = (state == S_FETCH) && !reset;
   assign mem_addr    = pc;
   assign instr_valid = (state == S_EXEC);
   assign halted      = (state == S_HALT);
   assign opcode      = op_q;
   assign operand     = opd_q;
   assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [3:0]  opcode;
   logic [11:0] operand;
   logic        instr_valid;
   logic        instr_done;
   logic        branch_take;
   logic [7:0]  branch_target;
   logic        halted;
   logic        fetch_err;

   logic [15:0] mem [256];
   assign mem_rdata = mem[mem_addr];

   instr_fetch_unit #(
      .ADDR_W(8), .RESET_PC(8'h00), .HALT_OP(4'hF), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .opcode(opcode),
      .operand(operand), .instr_valid(instr_valid), .instr_done(instr_done),
      .branch_take(branch_take), .branch_target(branch_target),
      .halted(halted), .fetch_err(fetch_err)
   );

   int tests  = 0;
   int failed = 0;

   // Behavioural reference: what the unit is doing, where it is, and what
   // it last accepted.
   typedef enum {M_FETCH, M_EXEC, M_HALT} mode_t;
   mode_t       m_mode;
   logic [7:0]  m_pc;
   logic [3:0]  m_op;
   logic [11:0] m_opd;
   logic        m_err;
   int          m_wait;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      if (reset) begin
         m_mode = M_FETCH; m_pc = 8'h00; m_op = 4'h0; m_opd = 12'h000;
         m_err = 1'b0; m_wait = 0;
      end else begin
         case (m_mode)
            M_FETCH: begin
               m_wait++;
               if (mem_ack) begin
                  {m_op, m_opd} = mem[m_pc];
                  m_pc   = m_pc + 8'd1;
                  m_wait = 0;
                  m_mode = M_EXEC;
               end else if (m_wait == TIMEOUT) begin
                  m_err  = 1'b1;
                  m_mode = M_HALT;
               end
            end
            M_EXEC: begin
               if (instr_done) begin
                  if (m_op == 4'hF) m_mode = M_HALT;
                  else begin
                     if (branch_take) m_pc = branch_target;
                     m_mode = M_FETCH;
                     m_wait = 0;
                  end
               end
            end
            default: ;
         endcase
      end
   endtask

   // Advance one clock and compare every output against the model.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("mem_req",     32'(mem_req),     32'((m_mode == M_FETCH) && !reset));
      check("mem_addr",    32'(mem_addr),    32'(m_pc));
      check("opcode",      32'(opcode),      32'(m_op));
      check("operand",     32'(operand),     32'(m_opd));
      check("instr_valid", 32'(instr_valid), 32'(m_mode == M_EXEC));
      check("halted",      32'(halted),      32'(m_mode == M_HALT));
      check("fetch_err",   32'(fetch_err),   32'(m_err));
   endtask

   task automatic drive(input logic r, input logic a, input logic d,
                        input logic t, input logic [7:0] tg);
      reset = r; mem_ack = a; instr_done = d; branch_take = t; branch_target = tg;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[8'h00] = 16'h8123;
      mem[8'h01] = 16'h3456;
      mem[8'h05] = 16'h2000;
      mem[8'h40] = 16'h1001;
      mem[8'hFF] = 16'hF000;
      m_mode = M_FETCH; m_pc = 8'h00; m_op = 4'h0; m_opd = 12'h000;
      m_err = 1'b0; m_wait = 0;

      // Reset, then straight-line fetch with ack in the first FETCH cycle.
      drive(1, 0, 0, 0, 8'h00);
      tick(); tick();
      check("rst_addr", 32'(mem_addr), 32'h0);
      check("rst_req", 32'(mem_req), 32'h0);
      drive(0, 1, 0, 0, 8'h00);
      tick();
      check("first_op", 32'(opcode), 32'h8);
      check("first_opd", 32'(operand), 32'h123);
      check("first_valid", 32'(instr_valid), 32'h1);
      check("first_pc", 32'(mem_addr), 32'h1);
      drive(0, 0, 1, 0, 8'h00);
      tick();
      check("next_addr", 32'(mem_addr), 32'h1);

      // Delayed ack: request held for three cycles, IR loaded only on ack.
      drive(0, 0, 0, 0, 8'h00);
      tick(); tick();
      check("delay_req", 32'(mem_req), 32'h1);
      check("delay_ir_hold", 32'(opcode), 32'h8);
      drive(0, 1, 0, 0, 8'h00);
      tick();
      check("delay_op", 32'(opcode), 32'h3);
      check("delay_err", 32'(fetch_err), 32'h0);

      // Branch to 5, fetch 16'h2000, then branch_take without instr_done.
      drive(0, 0, 1, 1, 8'h05);
      tick();
      check("br5_addr", 32'(mem_addr), 32'h05);
      drive(0, 1, 0, 0, 8'h00);
      tick();
      drive(0, 0, 0, 1, 8'h40);
      tick(); tick();
      check("nodone_pc", 32'(mem_addr), 32'h06);
      check("nodone_op", 32'(opcode), 32'h2);
      drive(0, 0, 1, 1, 8'h40);
      tick();
      check("br40_addr", 32'(mem_addr), 32'h40);

      // Wrap from 8'hFF and HALT; halted unit ignores acks.
      drive(0, 1, 0, 0, 8'h00);
      tick();
      drive(0, 0, 1, 1, 8'hFF);
      tick();
      drive(0, 1, 0, 0, 8'h00);
      tick();
      check("wrap_pc", 32'(mem_addr), 32'h00);
      check("halt_op", 32'(opcode), 32'hF);
      drive(0, 0, 1, 1, 8'h22);
      tick();
      check("halt_state", 32'(halted), 32'h1);
      check("halt_pc", 32'(mem_addr), 32'h00);
      for (int i = 0; i < 20; i++) begin
         drive(0, 1, 1'($urandom), 1'($urandom), 8'($urandom));
         tick();
         check("halt_noreq", 32'(mem_req), 32'h0);
      end
      drive(1, 0, 0, 0, 8'h00);
      tick();
      check("unhalt", 32'(halted), 32'h0);
      check("unhalt_pc", 32'(mem_addr), 32'h00);

      // Timeout with no ack.
      drive(0, 0, 0, 0, 8'h00);
      for (int i = 0; i < TIMEOUT - 1; i++) tick();
      check("to_pre_err", 32'(fetch_err), 32'h0);
      check("to_pre_req", 32'(mem_req), 32'h1);
      tick();
      check("to_err", 32'(fetch_err), 32'h1);
      check("to_halt", 32'(halted), 32'h1);
      check("to_req", 32'(mem_req), 32'h0);

      // Ack on exactly the last permitted cycle is accepted.
      drive(1, 0, 0, 0, 8'h00);
      tick();
      drive(0, 0, 0, 0, 8'h00);
      for (int i = 0; i < TIMEOUT - 1; i++) tick();
      drive(0, 1, 0, 0, 8'h00);
      tick();
      check("late_valid", 32'(instr_valid), 32'h1);
      check("late_err", 32'(fetch_err), 32'h0);
      check("late_op", 32'(opcode), 32'h8);

      // Reset in the middle of EXEC.
      drive(1, 0, 0, 0, 8'h00);
      tick();
      check("mid_valid", 32'(instr_valid), 32'h0);
      check("mid_op", 32'(opcode), 32'h0);
      check("mid_pc", 32'(mem_addr), 32'h00);
      drive(0, 0, 0, 0, 8'h00);
      tick();
      check("mid_fetch", 32'(mem_req), 32'h1);

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0, 1'($urandom), 8'($urandom));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
